// File: rtl/video_mode_ctrl.sv
// video_mode_ctrl
//   Measures incoming hsync/vsync timing and decides whether the video path goes through the
//   scandoubler (15 kHz sources) or bypasses it (31 kHz sources). Timing must be consistent
//   over several frames before it counts as locked. Mode changes are applied only at frame
//   start, so the output never switches mid-line.
//
// Parameters
//   HS_THRESH      line period (clk_x2 cycles) at or above which the source counts as 15 kHz
//   TOL            allowed line-period deviation between consecutive frames
//   STABLE_FRAMES  consecutive consistent frames needed for lock (1..15)
//
// Ports
//   clk_x2           single clock, rising edge
//   reset            synchronous, active-high
//   hs_in, vs_in     source syncs, synchronous to clk_x2; falling edges mark line/frame start
//   cfg_scanlines    requested scanline level
//   cfg_force_sd     force scandoubler on
//   cfg_disable_sd   force bypass (wins over cfg_force_sd)
//   sd_enable        1 = scandoubler path, 0 = bypass
//   scanlines_out    scanline level applied to the scandoubler
//   line_period      last measured line period
//   lines_per_frame  last measured line count per frame
//   locked           input timing is stable
//   mode_change      one-cycle pulse after sd_enable changes
module video_mode_ctrl #(
   parameter int unsigned HS_THRESH     = 1536,
   parameter int unsigned TOL           = 4,
   parameter int unsigned STABLE_FRAMES = 3
) (
   input  logic        clk_x2,
   input  logic        reset,
   input  logic        hs_in,
   input  logic        vs_in,
   input  logic [1:0]  cfg_scanlines,
   input  logic        cfg_force_sd,
   input  logic        cfg_disable_sd,
   output logic        sd_enable,
   output logic [1:0]  scanlines_out,
   output logic [11:0] line_period,
   output logic [9:0]  lines_per_frame,
   output logic        locked,
   output logic        mode_change
);

   localparam logic [1:0] StSearch  = 2'd0;
   localparam logic [1:0] StMeasure = 2'd1;
   localparam logic [1:0] StLocked  = 2'd2;

   localparam logic [11:0] HcntMax  = 12'hfff;
   localparam logic [9:0]  LcntMax  = 10'h3ff;
   localparam logic [12:0] TolW     = 13'(TOL);
   localparam logic [12:0] ThreshW  = 13'(HS_THRESH);
   localparam logic [3:0]  StableW  = 4'(STABLE_FRAMES);

   // Edge-detect registers hold the previous pin sample
   logic        hs_q, vs_q;
   logic [11:0] hcnt_q, hcnt_d;
   logic [9:0]  lcnt_q, lcnt_d;
   logic [11:0] line_period_q, line_period_d;
   logic [9:0]  lpf_q, lpf_d;
   logic [11:0] prev_period_q, prev_period_d;
   logic [9:0]  prev_lpf_q, prev_lpf_d;
   logic [1:0]  state_q, state_d;
   logic [3:0]  stable_q, stable_d;
   logic        sd_enable_q, sd_enable_d;
   logic [1:0]  scanlines_q, scanlines_d;
   logic        mode_change_q, mode_change_d;

   logic        hs_fall, vs_fall, hs_timeout;
   logic [11:0] period_new;
   logic [9:0]  lpf_new;
   logic [12:0] period_a, period_b, period_diff;
   logic        frame_consistent;
   logic        target_sd;
   logic        mode_update;
   logic [3:0]  stable_inc;

   assign hs_fall    = hs_q & ~hs_in;
   assign vs_fall    = vs_q & ~vs_in;
   assign hs_timeout = (hcnt_q == HcntMax);

   // Values as they will stand after this cycle; a vs edge that coincides with an hs edge
   // must see the line that just ended.
   assign period_new = hs_fall ? hcnt_q : line_period_q;
   assign lpf_new    = (hs_fall && (lcnt_q != LcntMax)) ? lcnt_q + 10'd1 : lcnt_q;

   // 13-bit magnitude so the subtraction cannot wrap
   assign period_a    = {1'b0, period_new};
   assign period_b    = {1'b0, prev_period_q};
   assign period_diff = (period_a >= period_b) ? period_a - period_b : period_b - period_a;

   assign frame_consistent = (period_diff <= TolW) && (lpf_new == prev_lpf_q);

   assign target_sd = cfg_disable_sd ? 1'b0 :
                      cfg_force_sd   ? 1'b1 :
                      (period_a >= ThreshW);

   assign mode_update = vs_fall && ((state_q == StLocked) || cfg_force_sd || cfg_disable_sd);
   assign stable_inc  = stable_q + 4'd1;

   // Measurement counters
   always_comb begin
      hcnt_d        = hcnt_q;
      lcnt_d        = lcnt_q;
      lpf_d         = lpf_q;
      prev_period_d = prev_period_q;
      prev_lpf_d    = prev_lpf_q;
      line_period_d = period_new;

      if (hs_fall) begin
         hcnt_d = 12'd0;
      end else if (!hs_timeout) begin
         hcnt_d = hcnt_q + 12'd1;
      end

      if (vs_fall) begin
         lcnt_d        = 10'd0;
         lpf_d         = lpf_new;
         prev_period_d = period_new;
         prev_lpf_d    = lpf_new;
      end else begin
         lcnt_d = lpf_new;
      end
   end

   // Lock state machine
   always_comb begin
      state_d  = state_q;
      stable_d = stable_q;

      if (hs_timeout) begin
         state_d  = StSearch;
         stable_d = 4'd0;
      end else if (vs_fall) begin
         case (state_q)
            StSearch: begin
               state_d  = StMeasure;
               stable_d = 4'd0;
            end
            StMeasure: begin
               if (frame_consistent) begin
                  stable_d = stable_inc;
                  if (stable_inc >= StableW) begin
                     state_d = StLocked;
                  end
               end else begin
                  stable_d = 4'd0;
               end
            end
            StLocked: begin
               if (!frame_consistent) begin
                  state_d  = StSearch;
                  stable_d = 4'd0;
               end
            end
            default: begin
               state_d  = StSearch;
               stable_d = 4'd0;
            end
         endcase
      end
   end

   // Mode selection, applied only at frame start
   always_comb begin
      sd_enable_d = sd_enable_q;
      scanlines_d = scanlines_q;
      if (mode_update) begin
         sd_enable_d = target_sd;
         scanlines_d = target_sd ? cfg_scanlines : 2'b00;
      end
      mode_change_d = (sd_enable_d != sd_enable_q);
   end

   always_ff @(posedge clk_x2) begin
      if (reset) begin
         hs_q          <= 1'b1;
         vs_q          <= 1'b1;
         hcnt_q        <= 12'd0;
         lcnt_q        <= 10'd0;
         line_period_q <= 12'd0;
         lpf_q         <= 10'd0;
         prev_period_q <= 12'd0;
         prev_lpf_q    <= 10'd0;
         state_q       <= StSearch;
         stable_q      <= 4'd0;
         sd_enable_q   <= 1'b1;
         scanlines_q   <= 2'b00;
         mode_change_q <= 1'b0;
      end else begin
         hs_q          <= hs_in;
         vs_q          <= vs_in;
         hcnt_q        <= hcnt_d;
         lcnt_q        <= lcnt_d;
         line_period_q <= line_period_d;
         lpf_q         <= lpf_d;
         prev_period_q <= prev_period_d;
         prev_lpf_q    <= prev_lpf_d;
         state_q       <= state_d;
         stable_q      <= stable_d;
         sd_enable_q   <= sd_enable_d;
         scanlines_q   <= scanlines_d;
         mode_change_q <= mode_change_d;
      end
   end

   assign sd_enable       = sd_enable_q;
   assign scanlines_out   = scanlines_q;
   assign line_period     = line_period_q;
   assign lines_per_frame = lpf_q;
   assign locked          = (state_q == StLocked);
   assign mode_change     = mode_change_q;

endmodule

// File: tb/tb_video_mode_ctrl.sv
// tb_video_mode_ctrl
//   Drives synthetic sync streams into video_mode_ctrl and compares every output on every cycle
//   against a frame-level reference model, plus literal expectations for the lock, jitter,
//   config, timeout, mode-switch, simultaneous-edge and reset scenarios.
//   Each line is PulseLen cycles of hsync low at its end; a frame's vsync falls on its last
//   line, vs_off cycles after that line's hsync fall (0 = same cycle).
module tb_video_mode_ctrl;

   localparam int HsThresh     = 1536;
   localparam int Tol          = 4;
   localparam int StableFrames = 3;
   localparam int PulseLen     = 16;

   logic        clk_x2 = 1'b0;
   logic        reset;
   logic        hs_in;
   logic        vs_in;
   logic [1:0]  cfg_scanlines;
   logic        cfg_force_sd;
   logic        cfg_disable_sd;
   logic        sd_enable;
   logic [1:0]  scanlines_out;
   logic [11:0] line_period;
   logic [9:0]  lines_per_frame;
   logic        locked;
   logic        mode_change;

   video_mode_ctrl #(
      .HS_THRESH     (HsThresh),
      .TOL           (Tol),
      .STABLE_FRAMES (StableFrames)
   ) dut (
      .clk_x2          (clk_x2),
      .reset           (reset),
      .hs_in           (hs_in),
      .vs_in           (vs_in),
      .cfg_scanlines   (cfg_scanlines),
      .cfg_force_sd    (cfg_force_sd),
      .cfg_disable_sd  (cfg_disable_sd),
      .sd_enable       (sd_enable),
      .scanlines_out   (scanlines_out),
      .line_period     (line_period),
      .lines_per_frame (lines_per_frame),
      .locked          (locked),
      .mode_change     (mode_change)
   );

   always #5 clk_x2 = ~clk_x2;

   int n_checks    = 0;
   int n_fail      = 0;
   int pulses_seen = 0;

   // Reference model: frame-level bookkeeping in plain integers
   int m_hs_prev, m_vs_prev;
   int m_age;          // cycles since the last line start, capped at 4095
   int m_lines;        // line starts seen in the current frame
   int m_period, m_lpf;
   int m_ref_period, m_ref_lpf;
   int m_phase;        // 0 hunting, 1 qualifying, 2 locked
   int m_streak;
   int m_sd, m_scan, m_pulse;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic model_reset();
      m_hs_prev    = 1;
      m_vs_prev    = 1;
      m_age        = 0;
      m_lines      = 0;
      m_period     = 0;
      m_lpf        = 0;
      m_ref_period = 0;
      m_ref_lpf    = 0;
      m_phase      = 0;
      m_streak     = 0;
      m_sd         = 1;
      m_scan       = 0;
      m_pulse      = 0;
   endtask

   task automatic model_step();
      int  line_start, frame_start, new_period, frame_lines, diff, target, old_sd;
      bit  consistent, timed_out;
      if (reset === 1'b1) begin
         model_reset();
         return;
      end
      line_start  = (m_hs_prev == 1 && hs_in == 1'b0) ? 1 : 0;
      frame_start = (m_vs_prev == 1 && vs_in == 1'b0) ? 1 : 0;
      timed_out   = (m_age == 4095);
      new_period  = line_start ? m_age : m_period;
      frame_lines = m_lines + line_start;
      if (frame_lines > 1023) frame_lines = 1023;
      diff = new_period - m_ref_period;
      if (diff < 0) diff = -diff;
      consistent = (diff <= Tol) && (frame_lines == m_ref_lpf);

      old_sd = m_sd;
      if (frame_start && (m_phase == 2 || cfg_force_sd || cfg_disable_sd)) begin
         if (cfg_disable_sd)    target = 0;
         else if (cfg_force_sd) target = 1;
         else                   target = (new_period >= HsThresh) ? 1 : 0;
         m_sd   = target;
         m_scan = target ? int'(cfg_scanlines) : 0;
      end
      m_pulse = (m_sd != old_sd) ? 1 : 0;

      if (timed_out) begin
         m_phase  = 0;
         m_streak = 0;
      end else if (frame_start) begin
         if (m_phase == 0) begin
            m_phase  = 1;
            m_streak = 0;
         end else if (m_phase == 1) begin
            if (consistent) begin
               m_streak++;
               if (m_streak >= StableFrames) m_phase = 2;
            end else begin
               m_streak = 0;
            end
         end else if (!consistent) begin
            m_phase = 0;
         end
      end

      if (frame_start) begin
         m_ref_period = new_period;
         m_ref_lpf    = frame_lines;
         m_lpf        = frame_lines;
         m_lines      = 0;
      end else begin
         m_lines = frame_lines;
      end
      m_period  = new_period;
      m_age     = line_start ? 0 : ((m_age < 4095) ? m_age + 1 : 4095);
      m_hs_prev = int'(hs_in);
      m_vs_prev = int'(vs_in);
   endtask

   // Per-cycle compare against the model
   initial begin
      forever begin
         @(posedge clk_x2);
         model_step();
         #1;
         if (mode_change === 1'b1) pulses_seen++;
         check("sd_enable",       32'(sd_enable),       m_sd);
         check("scanlines_out",   32'(scanlines_out),   m_scan);
         check("line_period",     32'(line_period),     m_period);
         check("lines_per_frame", 32'(lines_per_frame), m_lpf);
         check("locked",          32'(locked),          (m_phase == 2) ? 1 : 0);
         check("mode_change",     32'(mode_change),     m_pulse);
      end
   end

   task automatic drive_line(input int period, input bit last, input int vs_off);
      for (int c = 0; c < period; c++) begin
         @(negedge clk_x2);
         hs_in = (c >= period - PulseLen) ? 1'b0 : 1'b1;
         vs_in = (last && c >= period - PulseLen + vs_off) ? 1'b0 : 1'b1;
      end
   endtask

   task automatic drive_frame(input int period, input int nlines, input int vs_off);
      for (int l = 0; l < nlines; l++) drive_line(period, l == nlines - 1, vs_off);
   endtask

   task automatic pulse_reset();
      @(negedge clk_x2);
      reset = 1'b1;
      hs_in = 1'b1;
      vs_in = 1'b1;
      @(negedge clk_x2);
      reset = 1'b0;
   endtask

   initial begin
      int p0, drop_at, base, nl, per;
      reset          = 1'b1;
      hs_in          = 1'b1;
      vs_in          = 1'b1;
      cfg_scanlines  = 2'b00;
      cfg_force_sd   = 1'b0;
      cfg_disable_sd = 1'b0;
      repeat (3) @(negedge clk_x2);
      check("reset sd_enable",     32'(sd_enable), 1);
      check("reset scanlines",     32'(scanlines_out), 0);
      check("reset line_period",   32'(line_period), 0);
      check("reset lines",         32'(lines_per_frame), 0);
      check("reset locked",        32'(locked), 0);
      check("reset mode_change",   32'(mode_change), 0);
      reset = 1'b0;

      // Lock at 2048-cycle lines, simultaneous hs/vs edges
      for (int f = 1; f <= 4; f++) begin
         drive_frame(2048, 2, 0);
         check("lock progress", 32'(locked), (f == 4) ? 1 : 0);
      end
      check("lock line_period", 32'(line_period), 2047);
      check("lock lines",       32'(lines_per_frame), 2);
      check("lock sd_enable",   32'(sd_enable), 1);
      check("model pin period", m_period, 2047);
      check("model pin lines",  m_lpf, 2);

      // Jitter within tolerance holds lock; a large step drops it, then relock
      drive_frame(2046, 2, 0);
      check("jitter 2046 locked", 32'(locked), 1);
      drive_frame(2050, 2, 0);
      check("jitter 2050 locked", 32'(locked), 1);
      drive_frame(2060, 2, 0);
      check("jitter 2060 drop", 32'(locked), 0);
      for (int f = 1; f <= 4; f++) begin
         drive_frame(2048, 2, 0);
         check("relock progress", 32'(locked), (f == 4) ? 1 : 0);
      end

      // Config written mid-frame applies at the next frame start only
      drive_line(2048, 1'b0, 0);
      cfg_scanlines = 2'b10;
      repeat (20) @(negedge clk_x2);
      check("cfg mid-frame scanlines", 32'(scanlines_out), 0);
      drive_line(2048 - 20, 1'b1, 0);
      check("cfg applied scanlines", 32'(scanlines_out), 2);
      check("cfg applied sd_enable", 32'(sd_enable), 1);

      p0 = pulses_seen;
      cfg_force_sd   = 1'b1;
      cfg_disable_sd = 1'b1;
      drive_frame(2048, 2, 0);
      check("disable wins sd_enable", 32'(sd_enable), 0);
      check("disable scanlines",      32'(scanlines_out), 0);
      check("disable pulse count",    pulses_seen - p0, 1);

      p0 = pulses_seen;
      cfg_force_sd   = 1'b0;
      cfg_disable_sd = 1'b0;
      drive_frame(2048, 2, 0);
      check("restore sd_enable",  32'(sd_enable), 1);
      check("restore scanlines",  32'(scanlines_out), 2);
      check("restore pulse count", pulses_seen - p0, 1);

      // hs timeout while locked
      drop_at = -1;
      for (int i = 0; i < 4100; i++) begin
         @(negedge clk_x2);
         hs_in = 1'b1;
         vs_in = 1'b1;
         if (locked === 1'b0 && drop_at < 0) drop_at = i;
      end
      check("timeout drop in budget", 32'((drop_at >= 0 && drop_at <= 4096) ? 1 : 0), 1);
      check("timeout sd_enable held", 32'(sd_enable), 1);
      check("timeout scanlines held", 32'(scanlines_out), 2);

      // Relock at 1024-cycle lines, then switch to bypass at the following frame
      for (int f = 1; f <= 4; f++) begin
         drive_frame(1024, 2, 0);
         check("1024 lock progress", 32'(locked), (f == 4) ? 1 : 0);
      end
      check("1024 sd before switch", 32'(sd_enable), 1);
      p0 = pulses_seen;
      drive_frame(1024, 2, 0);
      check("switch sd_enable",   32'(sd_enable), 0);
      check("switch scanlines",   32'(scanlines_out), 0);
      check("switch pulse count", pulses_seen - p0, 1);
      check("switch line_period", 32'(line_period), 1023);

      // Reset mid-lock
      p0 = pulses_seen;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk_x2);
         hs_in = 1'b1;
         vs_in = 1'b1;
      end
      pulse_reset();
      check("midreset locked",      32'(locked), 0);
      check("midreset sd_enable",   32'(sd_enable), 1);
      check("midreset scanlines",   32'(scanlines_out), 0);
      check("midreset line_period", 32'(line_period), 0);
      repeat (20) @(negedge clk_x2);
      check("midreset no pulse", pulses_seen - p0, 0);

      // Randomized groups: nearly steady timing with jitter, random config and vs offset
      for (int g = 0; g < 2; g++) begin
         base = int'($urandom_range(1700, 300));
         nl   = int'($urandom_range(2, 1));
         if ($urandom_range(1, 0) == 1) pulse_reset();
         for (int f = 0; f < 5; f++) begin
            cfg_scanlines  = 2'($urandom_range(3, 0));
            cfg_force_sd   = ($urandom_range(3, 0) == 0);
            cfg_disable_sd = ($urandom_range(3, 0) == 0);
            per = base + int'($urandom_range(6, 0)) - 3;
            drive_frame(per, nl, int'($urandom_range(8, 0)));
         end
      end

      repeat (5) @(negedge clk_x2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
